thermo_ramp_checker: RTL and testbench
======================================

# thermo_ramp_checker

- Receive-side checker for the 8-level thermometer bar pattern produced by the counter/pattern-ROM generator (00000001, 00000011, … 11111111, wrapping back to 00000001).
- Samples the bar pattern on a strobe and decodes it back to a binary level.
- Locks onto the expected ramp sequence, then flags illegal codes and out-of-sequence steps, and keeps a saturating error count.
- Sits on the display/output side of the pattern path as a self-check and monitor block.

## Interface
Parameters:
- WIDTH, 8, number of bar segments; level width LW = $clog2(WIDTH)
- LOCK_COUNT, 4, consecutive in-sequence legal samples required to assert locked (2..15)
- ERR_W, 8, error counter width

Ports:
- clk  in  1  single clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- in_valid  in  1  sample strobe; in_data is evaluated only when high
- in_data  in  WIDTH  thermometer pattern under test
- err_clr  in  1  synchronous clear of err_count
- level  out  LW  last decoded legal level (number of ones minus 1)
- level_valid  out  1  one-cycle pulse; a legal sample was decoded
- code_err  out  1  one-cycle pulse; illegal pattern sampled
- seq_err  out  1  one-cycle pulse; legal sample not equal to expected level while locked
- locked  out  1  high in LOCKED state
- err_count  out  ERR_W  saturating count of code_err plus seq_err events

## Operation
- Legal code: in_data[0]=1 and (in_data & (in_data+1)) == 0. Gives exactly WIDTH legal codes; level = popcount-1.
- All-zero and any pattern with holes or a missing LSB are illegal.
- Expected next level: exp = (prev == WIDTH-1) ? 0 : prev+1.
- FSM states: SEARCH, TRACK, LOCKED. run is a 4-bit counter. Transitions happen only on in_valid=1.
- SEARCH:
  - legal sample: prev <= level, run <= 1, go to TRACK.
  - illegal sample: code_err, stay in SEARCH.
- TRACK:
  - legal sample equal to exp: run++. When run+1 == LOCK_COUNT, go to LOCKED.
  - legal sample not equal to exp: run <= 1, prev <= new level, stay in TRACK, no seq_err.
  - illegal sample: code_err, go to SEARCH.
- LOCKED:
  - legal sample equal to exp: stay in LOCKED.
  - legal sample not equal to exp: seq_err, prev <= new level, run <= 1, go to TRACK.
  - illegal sample: code_err, go to SEARCH.
- prev and level update on every legal sample in every state. level holds its value between samples.
- err_count increments by 1 on code_err or seq_err (never both in one cycle) and saturates at 2^ERR_W-1.
- err_clr has priority: if err_clr and an error occur in the same cycle, err_count becomes 0 and that error is not counted. The error pulse is still emitted.
- in_valid=0: no state, run, or prev change, and all pulses are low.

## Timing
- All outputs are registered.
- level, level_valid, code_err, seq_err, locked and err_count reflect a sample on the rising edge after the in_valid=1 cycle (1-cycle latency).
- Back-to-back in_valid every cycle is supported at full rate.
- Reset values (async on clear): state SEARCH, level 0, level_valid 0, code_err 0, seq_err 0, locked 0, err_count 0, run 0, prev 0.
- Reset mid-operation drops lock immediately. After release, lock requires LOCK_COUNT fresh in-sequence samples.
- Wrap-around: level WIDTH-1 followed by 0 is in sequence. Level 0 followed by WIDTH-1 is a sequence error.
- A repeated level (same sample twice) is a sequence error when locked.

## Structure
- Shared package thermo_pkg holds:
  - state enum {SEARCH, TRACK, LOCKED};
  - default WIDTH and LW constants;
  - function exp_next(prev) with the wrap rule.
- One combinational sub-module, thermo_decode (in_data -> legal, level), reusable by other bar-pattern consumers.
- Top level contains the FSM, the run counter, prev/level registers and the saturating error counter.

## Test plan
- Reset, then feed 00000001, 00000011, 00000111, 00001111 with in_valid every cycle. Required: level 0,1,2,3 each with level_valid; locked rises 1 cycle after the 4th sample; err_count=0.
- Locked, then feed 11111111 followed by 00000001. Required: level 7 then 0, no seq_err, locked stays high.
- Locked at level 3, then feed 00000101. Required: code_err pulse, state SEARCH, locked=0, err_count=1, level stays 3.
- Locked at level 2, then feed 00111111. Required: seq_err pulse, locked=0, level=5; 00000000 and 11111110 also yield code_err.
- Force 260 illegal samples with ERR_W=8. Required: err_count saturates at 255. Then assert err_clr together with one more error: required err_count=0 and code_err still pulses.
- Assert clear asynchronously mid-ramp while locked. Required: all outputs 0 immediately; after release, 3 in-sequence samples do not lock and the 4th does.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared types and helpers for thermometer bar-pattern consumers.
package thermo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LW    = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_e;

  // The ramp wraps from the full bar back to the single-segment bar.
  function automatic logic [31:0] exp_next(input logic [31:0] prev,
                                           input int unsigned width = DEF_WIDTH);
    return (prev == width - 1) ? 32'd0 : prev + 32'd1;
  endfunction

endpackage

// File: rtl/thermo_decode.sv
// Combinational thermometer decoder: legality check plus level = ones - 1.
module thermo_decode #(
  parameter int WIDTH = 8,
  localparam int LW   = $clog2(WIDTH),
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_data_i,
  output logic             legal_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] inc;
  logic [CW-1:0]    ones;

  // A contiguous run of ones from bit 0 clears completely when incremented.
  assign inc     = in_data_i + WIDTH'(1);
  assign legal_o = in_data_i[0] && ((in_data_i & inc) == '0);

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) ones = ones + CW'(in_data_i[i]);
  end

  assign level_o = LW'(ones - CW'(1));

endmodule

// File: rtl/thermo_ramp_checker.sv
// Receive-side ramp checker: locks onto the thermometer ramp, flags illegal
// codes and out-of-sequence steps, and keeps a saturating error count.
module thermo_ramp_checker
  import thermo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8,
  localparam int LW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             err_clr,
  output logic [LW-1:0]    level,
  output logic             level_valid,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  logic             dec_legal;
  logic [LW-1:0]    dec_level;

  state_e           state_q;
  logic [3:0]       run_q;
  logic [LW-1:0]    prev_q, level_q;
  logic             lv_q, cerr_q, serr_q, locked_q;
  logic [ERR_W-1:0] err_q;

  logic [LW-1:0]    exp_lvl;
  logic             in_seq, err_ev;

  thermo_decode #(.WIDTH(WIDTH)) u_dec (
    .in_data_i (in_data),
    .legal_o   (dec_legal),
    .level_o   (dec_level)
  );

  assign exp_lvl = LW'(exp_next(32'(prev_q), WIDTH));
  assign in_seq  = dec_legal && (dec_level == exp_lvl);
  assign err_ev  = in_valid && (!dec_legal || (state_q == LOCKED && !in_seq));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= SEARCH;
      run_q    <= '0;
      prev_q   <= '0;
      level_q  <= '0;
      lv_q     <= 1'b0;
      cerr_q   <= 1'b0;
      serr_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      lv_q   <= 1'b0;
      cerr_q <= 1'b0;
      serr_q <= 1'b0;
      if (in_valid) begin
        if (!dec_legal) begin
          cerr_q   <= 1'b1;
          state_q  <= SEARCH;
          run_q    <= '0;
          locked_q <= 1'b0;
        end else begin
          lv_q    <= 1'b1;
          level_q <= dec_level;
          prev_q  <= dec_level;
          case (state_q)
            SEARCH: begin
              run_q   <= 4'd1;
              state_q <= TRACK;
            end
            TRACK: begin
              if (in_seq) begin
                run_q <= run_q + 4'd1;
                if (run_q + 4'd1 == 4'(LOCK_COUNT)) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                run_q <= 4'd1;
              end
            end
            LOCKED: begin
              // run is left alone while locked; it only matters for re-acquire.
              if (!in_seq) begin
                serr_q   <= 1'b1;
                run_q    <= 4'd1;
                state_q  <= TRACK;
                locked_q <= 1'b0;
              end
            end
            default: begin
              state_q  <= SEARCH;
              run_q    <= '0;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Clear wins over a same-cycle error; the error pulse itself still fires.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)                        err_q <= '0;
    else if (err_clr)                 err_q <= '0;
    else if (err_ev && err_q != '1)   err_q <= err_q + ERR_W'(1);
  end

  assign level       = level_q;
  assign level_valid = lv_q;
  assign code_err    = cerr_q;
  assign seq_err     = serr_q;
  assign locked      = locked_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_thermo_ramp_checker.sv
// Self-checking bench for thermo_ramp_checker with a streak-based reference model.
module tb_thermo_ramp_checker;

  localparam int W    = 8;
  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       clear, in_valid, err_clr;
  logic [7:0] in_data;
  logic [2:0] level;
  logic       level_valid, code_err, seq_err, locked;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [2:0] m_level, m_prev;
  logic       m_lv, m_cerr, m_serr, m_locked;
  int         m_streak, m_err;

  thermo_ramp_checker #(.WIDTH(W), .LOCK_COUNT(LOCK), .ERR_W(8)) dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .err_clr(err_clr), .level(level), .level_valid(level_valid),
    .code_err(code_err), .seq_err(seq_err), .locked(locked),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bar(input int lvl);
    logic [15:0] t;
    t = (16'd1 << (lvl + 1)) - 16'd1;
    return t[7:0];
  endfunction

  task automatic model_reset();
    m_level = 0; m_prev = 0; m_lv = 0; m_cerr = 0; m_serr = 0;
    m_locked = 0; m_streak = 0; m_err = 0;
  endtask

  // Streak = consecutive legal samples each one above its predecessor (mod W).
  task automatic model_step(input logic v, input logic [7:0] d, input logic ec);
    int  ones;
    logic legal;
    ones  = $countones(d);
    legal = (ones > 0) && (d == bar(ones - 1));
    m_lv = 0; m_cerr = 0; m_serr = 0;
    if (v) begin
      if (!legal) begin
        m_cerr = 1; m_streak = 0; m_locked = 0;
      end else begin
        m_lv = 1;
        m_level = 3'(ones - 1);
        if (m_streak > 0 && (ones - 1) == (int'(m_prev) + 1) % W) begin
          if (m_streak < LOCK) m_streak++;
        end else begin
          if (m_locked) m_serr = 1;
          m_locked = 0;
          m_streak = 1;
        end
        m_prev = 3'(ones - 1);
        if (m_streak >= LOCK) m_locked = 1;
      end
    end
    if (ec) m_err = 0;
    else if ((m_cerr || m_serr) && m_err < 255) m_err++;
  endtask

  task automatic apply(input logic v, input logic [7:0] d, input logic ec);
    @(negedge clk);
    in_valid = v; in_data = d; err_clr = ec;
    @(posedge clk);
    #1;
    model_step(v, d, ec);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1; in_valid = 0; err_clr = 0; in_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({level, level_valid, code_err, seq_err, locked, err_count} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got lvl=%0d lv=%0b ce=%0b se=%0b lk=%0b ec=%0d want all 0",
               level, level_valid, code_err, seq_err, locked, err_count);
    end
  endtask

  task automatic test_ramp_lock();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, bar(i), 0);
      checks++;
      if (level !== 3'(i) || level_valid !== 1'b1) begin
        errors++;
        $display("FAIL ramp_level[%0d] got lvl=%0d lv=%0b want lvl=%0d lv=1", i, level, level_valid, i);
      end
      checks++;
      if (locked !== (i == 3)) begin
        errors++;
        $display("FAIL ramp_locked[%0d] got %0b want %0b", i, locked, (i == 3));
      end
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL ramp_err_count got %0d want 0", err_count);
    end
  endtask

  task automatic test_wrap();
    for (int i = 4; i < 8; i++) apply(1, bar(i), 0);
    checks++;
    if (level !== 3'd7 || !locked || seq_err) begin
      errors++;
      $display("FAIL wrap_top got lvl=%0d lk=%0b se=%0b want 7 1 0", level, locked, seq_err);
    end
    apply(1, 8'h01, 0);
    checks++;
    if (level !== 3'd0 || locked !== 1'b1 || seq_err !== 1'b0 || level_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero got lvl=%0d lk=%0b se=%0b lv=%0b want 0 1 0 1", level, locked, seq_err, level_valid);
    end
  endtask

  task automatic test_code_err();
    do_reset();
    for (int i = 0; i < 4; i++) apply(1, bar(i), 0);
    apply(1, 8'b0000_0101, 0);
    checks++;
    if (code_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1 ||
        level !== 3'd3 || level_valid !== 1'b0) begin
      errors++;
      $display("FAIL code_err got ce=%0b lk=%0b ec=%0d lvl=%0d lv=%0b want 1 0 1 3 0",
               code_err, locked, err_count, level, level_valid);
    end
    // back in search: one legal sample must not relock
    apply(1, bar(4), 0);
    checks++;
    if (locked !== 1'b0 || seq_err !== 1'b0 || level !== 3'd4) begin
      errors++;
      $display("FAIL search_after_code got lk=%0b se=%0b lvl=%0d want 0 0 4", locked, seq_err, level);
    end
  endtask

  task automatic test_seq_err();
    logic [7:0] bad [2];
    do_reset();
    apply(1, bar(7), 0); apply(1, bar(0), 0); apply(1, bar(1), 0); apply(1, bar(2), 0);
    checks++;
    if (locked !== 1'b1 || level !== 3'd2) begin
      errors++;
      $display("FAIL seq_prelock got lk=%0b lvl=%0d want 1 2", locked, level);
    end
    apply(1, 8'b0011_1111, 0);
    checks++;
    if (seq_err !== 1'b1 || locked !== 1'b0 || level !== 3'd5 || code_err !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL seq_err got se=%0b lk=%0b lvl=%0d ce=%0b ec=%0d want 1 0 5 0 1",
               seq_err, locked, level, code_err, err_count);
    end
    bad[0] = 8'h00; bad[1] = 8'hFE;
    for (int i = 0; i < 2; i++) begin
      apply(1, bad[i], 0);
      checks++;
      if (code_err !== 1'b1 || err_count !== 8'(2 + i) || level !== 3'd5) begin
        errors++;
        $display("FAIL illegal_%02h got ce=%0b ec=%0d lvl=%0d want 1 %0d 5",
                 bad[i], code_err, err_count, level, 2 + i);
      end
    end
    // repeated level while locked
    for (int i = 0; i < 4; i++) apply(1, bar(i), 0);
    apply(1, bar(3), 0);
    checks++;
    if (seq_err !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL repeat_level got se=%0b lk=%0b want 1 0", seq_err, locked);
    end
    // 0 followed by 7 while locked
    for (int i = 0; i < 4; i++) apply(1, bar(i + 4), 0);
    apply(1, bar(0), 0);
    apply(1, bar(7), 0);
    checks++;
    if (seq_err !== 1'b1 || level !== 3'd7) begin
      errors++;
      $display("FAIL zero_to_seven got se=%0b lvl=%0d want 1 7", seq_err, level);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 260; i++) apply(1, 8'h00, 0);
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate got %0d want 255", err_count);
    end
    apply(1, 8'h02, 1);
    checks++;
    if (err_count !== 8'd0 || code_err !== 1'b1) begin
      errors++;
      $display("FAIL err_clr_priority got ec=%0d ce=%0b want 0 1", err_count, code_err);
    end
    apply(0, 8'h00, 0);
    checks++;
    if (code_err !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL idle_after_clr got ce=%0b ec=%0d want 0 0", code_err, err_count);
    end
  endtask

  task automatic test_async_clear();
    do_reset();
    apply(1, 8'h05, 0);
    for (int i = 0; i < 5; i++) apply(1, bar(i), 0);
    @(negedge clk);
    clear = 1; in_valid = 0;
    #1;
    checks++;
    if ({level, level_valid, code_err, seq_err, locked, err_count} !== 15'd0) begin
      errors++;
      $display("FAIL async_clear got lvl=%0d lk=%0b ec=%0d want all 0", level, locked, err_count);
    end
    @(negedge clk);
    clear = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, bar(i + 2), 0);
      checks++;
      if (locked !== (i == 3)) begin
        errors++;
        $display("FAIL relock[%0d] got %0b want %0b", i, locked, (i == 3));
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [7:0] d;
    logic       v, ec;
    int         r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      d = bar((int'(m_prev) + 1) % W);
      else if (r <= 7) d = bar($urandom_range(0, 7));
      else             d = 8'($urandom);
      v  = ($urandom_range(0, 99) < 85);
      ec = ($urandom_range(0, 99) < 4);
      apply(v, d, ec);
      checks++;
      if (level !== m_level || level_valid !== m_lv || code_err !== m_cerr ||
          seq_err !== m_serr || locked !== m_locked || err_count !== 8'(m_err)) begin
        errors++;
        $display("FAIL random[%0d] d=%02h v=%0b got lvl=%0d lv=%0b ce=%0b se=%0b lk=%0b ec=%0d want %0d %0b %0b %0b %0b %0d",
                 n, d, v, level, level_valid, code_err, seq_err, locked, err_count,
                 m_level, m_lv, m_cerr, m_serr, m_locked, m_err);
      end
    end
  endtask

  initial begin
    clear = 1; in_valid = 0; err_clr = 0; in_data = 0;
    model_reset();
    test_reset();
    test_ramp_lock();
    test_wrap();
    test_code_err();
    test_seq_err();
    test_saturate();
    test_async_clear();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
